fht_but_pipe: RTL and testbench

- Parametrised, fully pipelined successor to the single-cycle 2-point FHT butterfly.
- Computes y0/y1 = x0 ± (cos·x1 + sin·x2) rotated term, with:
  - generic data and coefficient widths
  - per-sample scaling mode, round-half-up and output saturation
  - valid tagging, global clock-enable stall, sticky overflow counter
- Sits in the FHT stage datapath between the RAM read mux and the write-back path, and is instantiated once per butterfly lane.

---
 rtl/fht_pkg.sv | 31 +++
 rtl/fht_but_sat.sv | 38 +++
 rtl/fht_but_pipe.sv | 116 +++++++++++
 tb/tb_fht_but_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fht_pkg.sv
// Shared constants and helpers for the FHT butterfly datapath.
// Holds default widths, data limits and the signed saturation helper.
package fht_pkg;

    localparam int unsigned DefDSize = 17;
    localparam int unsigned DefWSize = 12;

    localparam logic signed [63:0] DataMax = (64'sd1 <<< (DefDSize - 1)) - 64'sd1;
    localparam logic signed [63:0] DataMin = -(64'sd1 <<< (DefDSize - 1));

    // Round half up when halving: (v + 1) >>> 1.
    function automatic logic signed [63:0] half_rnd(input logic signed [63:0] value);
        return (value + 64'sd1) >>> 1;
    endfunction

    // Clamp a wide signed value into a signed field of the given width.
    function automatic logic signed [63:0] sat_d(input logic signed [63:0] value,
                                                 input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/fht_but_sat.sv
// Combinational output lane: x0 +/- rot with a guard bit, optional
// round-half-up halving, then saturation to the data width.
module fht_but_sat
    import fht_pkg::*;
#(
    parameter int unsigned D_SIZE = DefDSize,
    parameter int unsigned ROT_W  = DefDSize + DefWSize + 1,
    parameter bit          SUB    = 1'b0
) (
    input  logic [D_SIZE-1:0] x0,
    input  logic [ROT_W-1:0]  rot,
    input  logic              scale,
    output logic [D_SIZE-1:0] y,
    output logic              clip
);

    localparam int unsigned SW = ROT_W + 1;

    logic signed [SW-1:0] x0_ext;
    logic signed [SW-1:0] rot_ext;
    logic signed [SW-1:0] sum;
    logic signed [63:0]   wide;
    logic signed [63:0]   satv;

    always_comb begin
        x0_ext  = SW'($signed(x0));
        rot_ext = SW'($signed(rot));
        sum     = SUB ? (x0_ext - rot_ext) : (x0_ext + rot_ext);
        wide    = 64'(sum);
        if (scale) begin
            wide = half_rnd(wide);
        end
        satv = sat_d(wide, D_SIZE);
        y    = D_SIZE'(satv);
        clip = (satv != wide);
    end

endmodule

// File: rtl/fht_but_pipe.sv
// Three-stage pipelined 2-point FHT butterfly with scaling, saturation,
// valid tagging, global stall and a sticky saturating overflow counter.
module fht_but_pipe
    import fht_pkg::*;
#(
    parameter int unsigned D_SIZE     = DefDSize,
    parameter int unsigned W_SIZE     = DefWSize,
    parameter int unsigned COEF_SHIFT = W_SIZE - 1,
    parameter int unsigned OVF_CNT_W  = 16
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic                 iCE,
    input  logic                 iVALID,
    input  logic [D_SIZE-1:0]    iX_0,
    input  logic [D_SIZE-1:0]    iX_1,
    input  logic [D_SIZE-1:0]    iX_2,
    input  logic [W_SIZE-1:0]    iSIN,
    input  logic [W_SIZE-1:0]    iCOS,
    input  logic                 iSCALE,
    input  logic                 iOVF_CLR,
    output logic                 oVALID,
    output logic [D_SIZE-1:0]    oY_0,
    output logic [D_SIZE-1:0]    oY_1,
    output logic                 oOVF,
    output logic [OVF_CNT_W-1:0] oOVF_CNT
);

    localparam int unsigned PW = D_SIZE + W_SIZE;
    localparam int unsigned RW = PW + 1;
    localparam logic signed [RW-1:0] Rnd = RW'(1) << (COEF_SHIFT - 1);

    logic signed [PW-1:0] p1_d, p2_d, p1_q, p2_q;
    logic signed [RW-1:0] prod, rot_d, rot_q;
    logic [D_SIZE-1:0]    x0_s1_q, x0_s2_q;
    logic                 scale_s1_q, scale_s2_q;
    logic                 vld_s1_q, vld_s2_q;
    logic [D_SIZE-1:0]    y0_d, y1_d;
    logic                 clip0, clip1, ovf_d;

    always_comb begin
        p1_d  = PW'($signed(iCOS)) * PW'($signed(iX_1));
        p2_d  = PW'($signed(iSIN)) * PW'($signed(iX_2));
        prod  = RW'(p1_q) + RW'(p2_q);
        rot_d = (prod + Rnd) >>> COEF_SHIFT;
        ovf_d = vld_s2_q & (clip0 | clip1);
    end

    fht_but_sat #(
        .D_SIZE(D_SIZE),
        .ROT_W (RW),
        .SUB   (1'b0)
    ) u_sat0 (
        .x0   (x0_s2_q),
        .rot  (rot_q),
        .scale(scale_s2_q),
        .y    (y0_d),
        .clip (clip0)
    );

    fht_but_sat #(
        .D_SIZE(D_SIZE),
        .ROT_W (RW),
        .SUB   (1'b1)
    ) u_sat1 (
        .x0   (x0_s2_q),
        .rot  (rot_q),
        .scale(scale_s2_q),
        .y    (y1_d),
        .clip (clip1)
    );

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            p1_q       <= '0;
            p2_q       <= '0;
            x0_s1_q    <= '0;
            scale_s1_q <= 1'b0;
            vld_s1_q   <= 1'b0;
            rot_q      <= '0;
            x0_s2_q    <= '0;
            scale_s2_q <= 1'b0;
            vld_s2_q   <= 1'b0;
            oY_0       <= '0;
            oY_1       <= '0;
            oVALID     <= 1'b0;
            oOVF       <= 1'b0;
        end else if (iCE) begin
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            x0_s1_q    <= iX_0;
            scale_s1_q <= iSCALE;
            vld_s1_q   <= iVALID;
            rot_q      <= rot_d;
            x0_s2_q    <= x0_s1_q;
            scale_s2_q <= scale_s1_q;
            vld_s2_q   <= vld_s1_q;
            oY_0       <= y0_d;
            oY_1       <= y1_d;
            oVALID     <= vld_s2_q;
            oOVF       <= ovf_d;
        end
    end

    // Clear wins over increment and works even while the pipe is stalled.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oOVF_CNT <= '0;
        end else if (iOVF_CLR) begin
            oOVF_CNT <= '0;
        end else if (iCE && ovf_d && (oOVF_CNT != {OVF_CNT_W{1'b1}})) begin
            oOVF_CNT <= oOVF_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_fht_but_pipe.sv
// Scoreboard bench for fht_but_pipe: directed vectors push expectations,
// a negedge monitor pops and compares every enabled valid output.
module tb_fht_but_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        vld;
    logic [16:0] x0, x1, x2;
    logic [11:0] sn, cs;
    logic        sc;
    logic        clr;
    logic        ov;
    logic [16:0] y0, y1;
    logic        ovf;
    logic [1:0]  cnt;

    typedef struct {
        real y0;
        real y1;
        bit  ovf;
        real tol;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   ce_last = 1'b0;

    int cosv[8] = '{2047, 1448, 0, -1448, -2047, -1448, 0, 1448};
    int sinv[8] = '{0, 1448, 2047, 1448, 0, -1448, -2047, -1448};

    always #5 clk = ~clk;

    fht_but_pipe #(
        .D_SIZE    (17),
        .W_SIZE    (12),
        .COEF_SHIFT(11),
        .OVF_CNT_W (2)
    ) dut (
        .iCLK    (clk),
        .iRESET  (rst_n),
        .iCE     (ce),
        .iVALID  (vld),
        .iX_0    (x0),
        .iX_1    (x1),
        .iX_2    (x2),
        .iSIN    (sn),
        .iCOS    (cs),
        .iSCALE  (sc),
        .iOVF_CLR(clr),
        .oVALID  (ov),
        .oY_0    (y0),
        .oY_1    (y1),
        .oOVF    (ovf),
        .oOVF_CNT(cnt)
    );

    function automatic real fabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) ce_last = ce && rst_n;

    always @(negedge clk) begin
        if (rst_n && ce_last && ov) begin
            exp_t e;
            int   a0, a1;
            checks++;
            a0 = int'($signed(y0));
            a1 = int'($signed(y1));
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: y0=%0d y1=%0d with empty scoreboard", a0, a1);
            end else begin
                e = sb.pop_front();
                if (fabs(real'(a0) - e.y0) > e.tol || fabs(real'(a1) - e.y1) > e.tol ||
                    ovf != e.ovf) begin
                    errors++;
                    $display("FAIL out: got y0=%0d y1=%0d ovf=%0b expected y0=%f y1=%f ovf=%0b tol=%f",
                             a0, a1, ovf, e.y0, e.y1, e.ovf, e.tol);
                end
            end
        end
        if (rst_n && !ov) begin
            checks++;
            if (ovf) begin
                errors++;
                $display("FAIL ovf_invalid: got ovf=1 expected 0 while oVALID=0");
            end
        end
    end

    task automatic put(input int a0, input int a1, input int a2, input int c, input int s,
                       input bit scl, input bit v, input real e0, input real e1,
                       input bit eo, input real tol);
        x0  = 17'(a0);
        x1  = 17'(a1);
        x2  = 17'(a2);
        cs  = 12'(c);
        sn  = 12'(s);
        sc  = scl;
        vld = v;
        if (v && ce && rst_n) sb.push_back('{e0, e1, eo, tol});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drain();
        vld = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("drain_left", sb.size(), 0);
    endtask

    task automatic put_ovf(input bit v);
        put(65535, 65535, 65535, 724, 724, 1'b0, v, 65535.0, 19200.0, 1'b1, 0.0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ce = 1'b1; vld = 1'b0; clr = 1'b0; sc = 1'b0;
        x0 = '0; x1 = '0; x2 = '0; sn = '0; cs = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", int'(ov), 0);
        check("rst_y0", int'(y0), 0);
        check("rst_y1", int'(y1), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_cnt", int'(cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic and rounding vectors
        put(1000, 2000, 0, 1024, 0, 1'b1, 1'b1, 1000.0, 0.0, 1'b0, 0.0);
        put(0, -3, 0, 1024, 0, 1'b1, 1'b1, 0.0, 1.0, 1'b0, 0.0);
        drain();
        put_ovf(1'b1);
        drain();
        check("cnt_after_one_ovf", int'(cnt), 1);

        // Special-angle sweep against a real-valued model
        for (int k = 0; k < 8; k++) begin
            for (int m = 0; m < 8; m++) begin
                int  a0, a1, a2;
                bit  scl;
                real r, e0, e1;
                a0  = (m & 1) ? -20000 : 20000;
                a1  = (m & 2) ? -15000 : 15000;
                a2  = (m & 4) ? -9000 : 9000;
                scl = ((k + m) % 2) == 1;
                r   = real'(cosv[k] * a1 + sinv[k] * a2) / 2048.0;
                e0  = real'(a0) + r;
                e1  = real'(a0) - r;
                if (scl) begin
                    e0 = e0 / 2.0;
                    e1 = e1 / 2.0;
                end
                put(a0, a1, a2, cosv[k], sinv[k], scl, 1'b1, e0, e1, 1'b0, 1.0);
            end
        end
        drain();

        // Stall: two frozen cycles after sample 2, one more once outputs flow
        for (int k = 1; k <= 2; k++)
            put(100 * k, 20 * k, 0, 1024, 0, 1'b0, 1'b1, 110.0 * k, 90.0 * k, 1'b0, 0.0);
        ce = 1'b0;
        put(7, 9, 11, 300, 200, 1'b0, 1'b1, 0.0, 0.0, 1'b0, 0.0);
        put(8, 9, 11, 300, 200, 1'b1, 1'b1, 0.0, 0.0, 1'b0, 0.0);
        ce = 1'b1;
        for (int k = 3; k <= 4; k++)
            put(100 * k, 20 * k, 0, 1024, 0, 1'b0, 1'b1, 110.0 * k, 90.0 * k, 1'b0, 0.0);
        check("pre_stall_valid", int'(ov), 1);
        check("pre_stall_y0", int'($signed(y0)), 220);
        ce = 1'b0;
        put(5, 5, 5, 5, 5, 1'b0, 1'b1, 0.0, 0.0, 1'b0, 0.0);
        check("stall_hold_valid", int'(ov), 1);
        check("stall_hold_y0", int'($signed(y0)), 220);
        check("stall_hold_y1", int'($signed(y1)), 180);
        ce = 1'b1;
        for (int k = 5; k <= 6; k++)
            put(100 * k, 20 * k, 0, 1024, 0, 1'b0, 1'b1, 110.0 * k, 90.0 * k, 1'b0, 0.0);
        drain();

        // Counter: clear while stalled, saturate, clear beats increment, invalid ignored
        ce = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        ce = 1'b1;
        check("cnt_clr_stalled", int'(cnt), 0);
        for (int i = 0; i < 8; i++) put_ovf(1'b1);
        drain();
        check("cnt_saturated", int'(cnt), 3);
        put_ovf(1'b1);
        idle(1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("cnt_clr_priority", int'(cnt), 0);
        put_ovf(1'b0);
        idle(4);
        check("cnt_invalid_ovf", int'(cnt), 0);
        drain();

        // Reset with samples in flight
        put_ovf(1'b1);
        put_ovf(1'b1);
        put_ovf(1'b1);
        x0 = 17'(123);
        vld = 1'b1;
        check("pre_rst_valid", int'(ov), 1);
        check("pre_rst_cnt", int'(cnt), 1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_valid", int'(ov), 0);
        check("mid_rst_y0", int'(y0), 0);
        check("mid_rst_y1", int'(y1), 0);
        check("mid_rst_ovf", int'(ovf), 0);
        check("mid_rst_cnt", int'(cnt), 0);
        @(negedge clk);
        @(negedge clk);
        vld = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_flushed", int'(ov), 0);
        end
        put(1000, 2000, 0, 1024, 0, 1'b1, 1'b1, 1000.0, 0.0, 1'b0, 0.0);
        vld = 1'b0;
        check("lat_cycle1", int'(ov), 0);
        @(negedge clk);
        check("lat_cycle2", int'(ov), 0);
        @(negedge clk);
        check("lat_cycle3", int'(ov), 1);
        check("lat_y0", int'($signed(y0)), 1000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
